pipe_reg_em: RTL

Parametrised EX→MEM pipeline register for the pipelined RISC-V core. It sits between the execute and memory stages and replaces the plain, always-loading stage register with stall (hold), flush (bubble insertion), a valid bit and control-field transport. It also pre-computes store byte lanes and misalignment at the stage boundary, and supports a configurable register depth for retiming. All state lives in a chain of `DEPTH` identical register slices.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/pipe_slice.sv | 29 ++
 rtl/pipe_reg_em.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipelined RISC-V core's stage registers.
package pipeline_pkg;

  // Slices are sized for the widest datapath; narrower builds leave the upper bits unused.
  localparam int MAX_DW = 64;
  localparam int MAX_BE = MAX_DW / 8;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;
  localparam logic [1:0] F3_SD = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [MAX_DW-1:0] alu_result;
    logic [MAX_DW-1:0] write_data;
    logic [MAX_DW-1:0] pc_plus4;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_write;
    result_src_e       result_src;
    logic [2:0]        funct3;
    logic [MAX_BE-1:0] byte_en;
    logic              misalign;
  } em_bundle_t;

endpackage

// File: rtl/pipe_slice.sv
// One EX->MEM register slice: async reset, synchronous clear, load enable.
module pipe_slice
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  em_bundle_t d,
  output em_bundle_t q
);

  em_bundle_t bundle_d, bundle_q;

  // Clear beats enable so a flush during a stall still empties the slice.
  always_comb begin
    bundle_d = bundle_q;
    if (clr)     bundle_d = '0;
    else if (en) bundle_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bundle_q <= '0;
    else     bundle_q <= bundle_d;
  end

  assign q = bundle_q;

endmodule

// File: rtl/pipe_reg_em.sv
// EX->MEM pipeline register with stall/flush, store lane steering and DEPTH-slice retiming chain.
module pipe_reg_em
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallM,
  input  logic                  FlushM,
  input  logic                  ValidE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic [DATA_WIDTH-1:0] WriteDataE,
  input  logic [DATA_WIDTH-1:0] PCPlus4E,
  input  logic [4:0]            RdE,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic [2:0]            Funct3E,
  output logic                  ValidM,
  output logic [DATA_WIDTH-1:0] ALUResultM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic [4:0]            RdM,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [2:0]            Funct3M,
  output logic [BE_WIDTH-1:0]   ByteEnM,
  output logic                  MisalignM
);

  localparam int LW = $clog2(BE_WIDTH);

  logic [LW-1:0]         lane;
  logic [BE_WIDTH-1:0]   byte_en;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  misalign;
  em_bundle_t            cap;
  em_bundle_t            chain [DEPTH];

  assign lane = ALUResultE[LW-1:0];

  // Replicating the narrow datum across every lane is equivalent to shifting it to its lane.
  always_comb begin
    byte_en  = '0;
    misalign = 1'b0;
    st_data  = WriteDataE;
    if (MemWriteE) begin
      case (Funct3E[1:0])
        F3_SB: begin
          byte_en = BE_WIDTH'(1) << lane;
          st_data = {BE_WIDTH{WriteDataE[7:0]}};
        end
        F3_SH: begin
          byte_en  = BE_WIDTH'(2'b11) << lane;
          misalign = lane[0];
          st_data  = {(DATA_WIDTH/16){WriteDataE[15:0]}};
        end
        F3_SW: begin
          byte_en  = BE_WIDTH'(4'hF) << lane;
          misalign = (lane[1:0] != 2'b00);
          st_data  = {(DATA_WIDTH/32){WriteDataE[31:0]}};
        end
        default: begin
          byte_en  = '1;
          misalign = (DATA_WIDTH != 64) || (lane != '0);
        end
      endcase
      if (misalign) byte_en = '0;
    end
  end

  always_comb begin
    cap            = '0;
    cap.valid      = ValidE;
    cap.alu_result = MAX_DW'(ALUResultE);
    cap.write_data = MAX_DW'(st_data);
    cap.pc_plus4   = MAX_DW'(PCPlus4E);
    cap.rd         = RdE;
    cap.reg_write  = RegWriteE & ValidE;
    cap.mem_write  = MemWriteE & ValidE & ~misalign;
    cap.result_src = result_src_e'(ResultSrcE);
    cap.funct3     = Funct3E;
    cap.byte_en    = MAX_BE'(byte_en);
    cap.misalign   = misalign;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    pipe_slice u_slice (
      .clk (clk),
      .rst (rst),
      .clr (FlushM),
      .en  (~StallM),
      .d   ((k == 0) ? cap : chain[(k == 0) ? 0 : k-1]),
      .q   (chain[k])
    );
  end

  assign ValidM     = chain[DEPTH-1].valid;
  assign ALUResultM = chain[DEPTH-1].alu_result[DATA_WIDTH-1:0];
  assign WriteDataM = chain[DEPTH-1].write_data[DATA_WIDTH-1:0];
  assign PCPlus4M   = chain[DEPTH-1].pc_plus4[DATA_WIDTH-1:0];
  assign RdM        = chain[DEPTH-1].rd;
  assign RegWriteM  = chain[DEPTH-1].reg_write;
  assign MemWriteM  = chain[DEPTH-1].mem_write;
  assign ResultSrcM = chain[DEPTH-1].result_src;
  assign Funct3M    = chain[DEPTH-1].funct3;
  assign ByteEnM    = chain[DEPTH-1].byte_en[BE_WIDTH-1:0];
  assign MisalignM  = chain[DEPTH-1].misalign;

  if (DATA_WIDTH < MAX_DW) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{chain[DEPTH-1].alu_result[MAX_DW-1:DATA_WIDTH],
                         chain[DEPTH-1].write_data[MAX_DW-1:DATA_WIDTH],
                         chain[DEPTH-1].pc_plus4[MAX_DW-1:DATA_WIDTH],
                         chain[DEPTH-1].byte_en[MAX_BE-1:BE_WIDTH]};
  end

endmodule
